// File: rtl/alu_pkg.sv
// Shared types and constants for the add/sub arbiter datapath.
package alu_pkg;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   typedef logic req_id_t;

   localparam logic [15:0] SAT_MAX = 16'h7FFF;
   localparam logic [15:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/claAddSub.sv
// 16-bit two-level carry-lookahead add/sub with signed saturation.
module claAddSub
   import alu_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        Cin,
   input  logic        isSub,
   output logic [15:0] sum,
   output logic        ovfl
);

   logic [15:0] b_eff;
   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [15:0] raw;
   logic [3:0]  gg;
   logic [3:0]  gp;
   logic [3:0]  gc;
   logic        c0;

   // Carry into each of four positions from generate/propagate of the lower three.
   function automatic logic [3:0] cla4(input logic [2:0] gi, input logic [2:0] pi,
                                       input logic ci);
      logic [3:0] co;
      co[0] = ci;
      co[1] = gi[0] | (pi[0] & ci);
      co[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
      co[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & ci);
      return co;
   endfunction

   function automatic logic grp_gen(input logic [3:0] gi, input logic [3:1] pi);
      return gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
   endfunction

   always_comb begin
      b_eff = isSub ? ~b : b;
      // Cin acts as a borrow when subtracting: a - b - Cin.
      c0    = isSub ^ Cin;
      g     = a & b_eff;
      p     = a ^ b_eff;
      gg    = '0;
      gp    = '0;
      c     = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         gg[k] = grp_gen(g[k*4 +: 4], p[k*4+1 +: 3]);
         gp[k] = &p[k*4 +: 4];
      end
      gc = cla4(gg[2:0], gp[2:0], c0);
      for (int unsigned k = 0; k < 4; k++) begin
         c[k*4 +: 4] = cla4(g[k*4 +: 3], p[k*4 +: 3], gc[k]);
      end
      raw  = p ^ c;
      ovfl = (a[15] == b_eff[15]) && (raw[15] != a[15]);
      sum  = ovfl ? (a[15] ? SAT_MIN : SAT_MAX) : raw;
   end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin two-port front end for the shared saturating add/sub unit.
module addsub_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [WIDTH-1:0] resp_sum,
   output logic             resp_ovfl
);

   state_t           state;
   req_id_t          prio;
   req_id_t          gid;
   req_id_t          gnt;
   logic             gnt_any;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_sub;
   logic [WIDTH-1:0] sat_sum;
   logic             sat_ovfl;

   always_comb begin
      gnt_any    = req0_valid | req1_valid;
      gnt        = (req0_valid & req1_valid) ? prio : req1_valid;
      req0_ready = (state == IDLE) & req0_valid & (gnt == 1'b0);
      req1_ready = (state == IDLE) & req1_valid & (gnt == 1'b1);
   end

   claAddSub u_cla (
      .a     (op_a),
      .b     (op_b),
      .Cin   (1'b0),
      .isSub (op_sub),
      .sum   (sat_sum),
      .ovfl  (sat_ovfl)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         prio        <= 1'b0;
         gid         <= 1'b0;
         op_a        <= '0;
         op_b        <= '0;
         op_sub      <= 1'b0;
         resp_sum    <= '0;
         resp_ovfl   <= 1'b0;
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  op_a   <= gnt ? req1_a : req0_a;
                  op_b   <= gnt ? req1_b : req0_b;
                  op_sub <= gnt ? req1_sub : req0_sub;
                  gid    <= gnt;
                  prio   <= ~gnt;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               resp_sum    <= sat_sum;
               resp_ovfl   <= sat_ovfl;
               resp0_valid <= ~gid;
               resp1_valid <= gid;
               state       <= RESP;
            end
            RESP: begin
               if ((resp0_valid & resp0_ready) | (resp1_valid & resp1_ready)) begin
                  resp0_valid <= 1'b0;
                  resp1_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: transaction-level reference model checked every cycle.
module tb_addsub_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_sub;
   logic        req1_valid, req1_ready, req1_sub;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
   logic [15:0] resp_sum;
   logic        resp_ovfl;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   addsub_arbiter #(.WIDTH(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_sub    (req0_sub),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_sub    (req1_sub),
      .resp0_valid (resp0_valid),
      .resp0_ready (resp0_ready),
      .resp1_valid (resp1_valid),
      .resp1_ready (resp1_ready),
      .resp_sum    (resp_sum),
      .resp_ovfl   (resp_ovfl)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an operation is either absent, being computed, or awaiting pickup.
   bit          model_ok = 1'b0;
   int          stage = 0;
   bit          owner, last;
   logic [15:0] cap_a, cap_b, exp_sum;
   bit          cap_sub, exp_ovfl;
   int          grants[$];
   bit          e_r0, e_r1;
   int          x, y, r;

   always @(negedge clk) begin
      if (model_ok) begin
         e_r0 = (stage == 0) && req0_valid && (!req1_valid || last == 1'b1);
         e_r1 = (stage == 0) && req1_valid && (!req0_valid || last == 1'b0);
         check("req0_ready", req0_ready, e_r0);
         check("req1_ready", req1_ready, e_r1);
         check("resp0_valid", resp0_valid, (stage == 2) && (owner == 1'b0));
         check("resp1_valid", resp1_valid, (stage == 2) && (owner == 1'b1));
         check("resp_sum", resp_sum, exp_sum);
         check("resp_ovfl", resp_ovfl, exp_ovfl);
         if (req0_ready === 1'b1 && req0_valid) grants.push_back(0);
         if (req1_ready === 1'b1 && req1_valid) grants.push_back(1);
      end
      if (rst) begin
         model_ok = 1'b1;
         stage    = 0;
         last     = 1'b1;
         exp_sum  = 16'h0000;
         exp_ovfl = 1'b0;
      end else if (model_ok) begin
         case (stage)
            0: if (req0_valid || req1_valid) begin
                  owner   = (req0_valid && req1_valid) ? ~last : req1_valid;
                  cap_a   = owner ? req1_a : req0_a;
                  cap_b   = owner ? req1_b : req0_b;
                  cap_sub = owner ? req1_sub : req0_sub;
                  last    = owner;
                  stage   = 1;
               end
            1: begin
                  x = $signed(cap_a);
                  y = $signed(cap_b);
                  r = cap_sub ? x - y : x + y;
                  if (r > 32767) begin
                     exp_sum = 16'h7FFF; exp_ovfl = 1'b1;
                  end else if (r < -32768) begin
                     exp_sum = 16'h8000; exp_ovfl = 1'b1;
                  end else begin
                     exp_sum = r[15:0]; exp_ovfl = 1'b0;
                  end
                  stage = 2;
               end
            default: if ((owner == 1'b0 && resp0_ready) || (owner == 1'b1 && resp1_ready)) stage = 0;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 16'h7FFF;
         1: return 16'h8000;
         2: return 16'hFFFF;
         3: return 16'h0000;
         4: return 16'h0001;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic scramble_operands();
      req0_a = pick_operand(); req0_b = pick_operand(); req0_sub = 1'($urandom);
      req1_a = pick_operand(); req1_b = pick_operand(); req1_sub = 1'($urandom);
   endtask

   task automatic run_op(input bit p, input logic [15:0] a, input logic [15:0] b, input bit s,
                         input logic [15:0] es, input bit eo);
      int  k;
      bit  hs;
      if (p == 1'b0) begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = s;
      end else begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = s;
      end
      #1;
      hs = 1'b0;
      for (k = 0; k < 20; k++) begin
         if ((p ? req1_ready : req0_ready) === 1'b1) begin
            hs = 1'b1;
            break;
         end
         tick();
         #1;
      end
      check("op_handshake", hs, 1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      scramble_operands();
      #1;
      k = 1;
      while ((p ? resp1_valid : resp0_valid) !== 1'b1 && k < 10) begin
         tick();
         #1;
         k++;
      end
      check("op_latency", k, 2);
      check("op_sum", resp_sum, es);
      check("op_ovfl", resp_ovfl, eo);
      check("op_other_valid", p ? resp0_valid : resp1_valid, 0);
      check("model_sum_pin", exp_sum, es);
      check("model_ovfl_pin", exp_ovfl, eo);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   logic [15:0] held;

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req0_sub = 1'b0;
      req1_a = '0; req1_b = '0; req1_sub = 1'b0;
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      check("rst_resp0_valid", resp0_valid, 0);
      check("rst_resp1_valid", resp1_valid, 0);
      check("rst_sum", resp_sum, 16'h0000);
      check("rst_ovfl", resp_ovfl, 0);
      tick();

      run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1);
      run_op(1'b1, 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1);
      run_op(1'b1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0);
      run_op(1'b0, 16'h1234, 16'h0F00, 1'b0, 16'h2134, 1'b0);
      run_op(1'b0, 16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b1);

      // Continuous tie after reset: alternation starting at requester 0.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      grants.delete();
      scramble_operands();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (14) tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (4) tick();
      check("tie_grant_count", grants.size() >= 4, 1);
      if (grants.size() >= 4) begin
         for (int i = 0; i < 4; i++) check("tie_grant_order", grants[i], i % 2);
      end

      // Response stall on port 0 while requester 1 waits.
      resp0_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 16'h0100; req0_b = 16'h0023; req0_sub = 1'b0;
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      tick();
      #1;
      held = resp_sum;
      check("stall_sum", resp_sum, 16'h0123);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", resp0_valid, 1);
         check("stall_hold", resp_sum, held);
         check("stall_req0_ready", req0_ready, 0);
         check("stall_req1_ready", req1_ready, 0);
         tick();
         #1;
      end
      resp0_ready = 1'b1;
      tick();
      #1;
      check("release_idle", req1_ready, 1);
      check("release_resp0", resp0_valid, 0);
      tick();
      req1_valid = 1'b0;
      repeat (4) tick();

      // Reset while an operation is in EXEC.
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      tick();
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      check("midrst_resp0", resp0_valid, 0);
      check("midrst_resp1", resp1_valid, 0);
      check("midrst_sum", resp_sum, 16'h0000);
      check("midrst_ovfl", resp_ovfl, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("midrst_no_resp", resp0_valid | resp1_valid, 0);
      end
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      check("midrst_tie_r0", req0_ready, 1);
      check("midrst_tie_r1", req1_ready, 0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (4) tick();

      // Randomised traffic with occasional stalls and resets.
      for (int i = 0; i < 600; i++) begin
         req0_valid  = ($urandom_range(0, 99) < 55);
         req1_valid  = ($urandom_range(0, 99) < 55);
         resp0_ready = ($urandom_range(0, 99) < 70);
         resp1_ready = ($urandom_range(0, 99) < 70);
         rst         = ($urandom_range(0, 99) < 2);
         scramble_operands();
         tick();
      end
      rst = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      resp0_ready = 1'b1;
      resp1_ready = 1'b1;
      repeat (6) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Two-port arbiter and sequencer for the shared 16-bit saturating CLA add/sub unit. It accepts operations from two requesters, typically the ALU execute path (port 0) and the address/branch-offset path (port 1). It grants one operation at a time, round-robin, using a valid/ready handshake. It registers the operands, runs them through a single adder instance, and returns a registered saturated result plus an overflow flag to the granted requester.

## Interface
Parameters:
- WIDTH, 16, operand/result width; fixed at 16 for the current datapath.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0's operation is accepted this cycle.
- req0_a  in  16  requester 0 operand A, two's complement.
- req0_b  in  16  requester 0 operand B, two's complement.
- req0_sub  in  1  requester 0 operation: 1 = A−B, 0 = A+B.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same meanings for requester 1.
- resp0_valid  out  1  result available for requester 0.
- resp0_ready  in  1  requester 0 takes the result.
- resp1_valid  out  1  result available for requester 1.
- resp1_ready  in  1  requester 1 takes the result.
- resp_sum  out  16  saturated result, shared by both responders.
- resp_ovfl  out  1  signed overflow occurred, meaning the result was clamped.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset → IDLE.
- IDLE:
  - If exactly one reqN_valid is high, grant that requester.
  - If both are high, grant the requester selected by the round-robin pointer `prio`.
  - reqN_ready is combinationally high only for the granted requester, and only in IDLE.
  - On the handshake: capture a, b, sub and the grant id; set `prio` to the other requester; go to EXEC.
- EXEC:
  - The captured operands drive the adder: B is inverted when sub=1, and carry-in = sub.
  - Register the saturated sum and ovfl; go to RESP.
- RESP:
  - respG_valid is high for the granted id only. resp_sum and resp_ovfl are held stable.
  - On respG_valid & respG_ready, go to IDLE.
  - No new grant is made in the cycle of the response handshake.
- Arithmetic and saturation:
  - Exact result = A ± B, evaluated in 17-bit signed.
  - If the result is > 32767: resp_sum = 0x7FFF, resp_ovfl = 1.
  - If the result is < −32768: resp_sum = 0x8000, resp_ovfl = 1.
  - Otherwise resp_sum = exact[15:0], resp_ovfl = 0.
  - Overflow is detected from the pre-saturation sign bits: A and effective B have equal signs and the raw sum sign differs.
  - Carry-out is not exported.
- Outputs outside RESP: resp_sum and resp_ovfl keep their last registered value. Only the valid signals qualify them.

## Timing
- Reset values: state = IDLE, prio = 0 (requester 0 wins the first tie), all ready and valid outputs = 0, resp_sum = 0x0000, resp_ovfl = 0, captured operand registers = 0.
- Cycle sequence:
  - Cycle n: request handshake.
  - Cycle n+1: EXEC.
  - Cycle n+2: respG_valid is high.
- Minimum issue interval is 3 cycles per operation when the response is taken immediately. A response stall extends RESP indefinitely.
- While not in IDLE, both reqN_ready = 0. Requests are held by the requester, not queued.
- A requester that drops reqN_valid before its handshake loses nothing; there is no internal state for it.
- rst asserted in any state forces reset values at the next edge. An in-flight operation is discarded and no response is produced.
- Simultaneous valid on both ports at reset: requester 0 is served first, then requester 1, then alternation.
- Any change in reqN_a/b/sub after the handshake has no effect on the in-flight operation.

## Structure
- Shared package `alu_pkg`:
  - state enum {IDLE, EXEC, RESP};
  - constants SAT_MAX = 16'h7FFF and SAT_MIN = 16'h8000;
  - requester id type (1 bit).
- One sub-module is natural: the existing 16-bit CLA saturating add/sub unit `claAddSub`, instantiated once with Cin tied 0 and isSub = captured sub.
- The arbiter grant logic stays inline; it is too small to split out.

## Test plan
- Saturating add on port 0: a=0x7FFF, b=0x0001, sub=0 → resp0_valid at cycle n+2, resp_sum=0x7FFF, resp_ovfl=1.
- Saturating subtract on port 1: a=0x8000, b=0x0001, sub=1 → resp_sum=0x8000, resp_ovfl=1. A normal subtract, a=0x0003, b=0x0005 → resp_sum=0xFFFE, resp_ovfl=0.
- Both valid, held continuously after reset: grants go 0, 1, 0, 1. Each response reaches only the matching resp valid, and req ready never overlaps RESP.
- Response stall: hold resp0_ready=0 for 5 cycles → resp_sum stable, both req ready = 0 throughout. Release → IDLE on the next cycle.
- Reset mid-EXEC: assert rst for 1 cycle → no resp valid. The next tie is granted to requester 0, and all outputs match reset values.
- Operand change after the handshake: change req0_a in cycle n+1 → the result reflects the captured value.
